// File: rtl/ca_pkt_if.sv
// ca_pkt_if: command channel from the scheduler into the CA packet engine
// master: drives cmd_valid and the decoded command fields, samples cmd_ready
// slave:  samples cmd_valid and the fields, drives cmd_ready
interface ca_pkt_if #(
  parameter int BG_W  = 3,
  parameter int BA_W  = 2,
  parameter int ROW_W = 16,
  parameter int COL_W = 10
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic             cmd_ap;
  logic [BG_W-1:0]  cmd_bg;
  logic [BA_W-1:0]  cmd_ba;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic [7:0]       cmd_mra;
  logic [7:0]       cmd_mrd;
  modport master (
    output cmd_valid, cmd_op, cmd_ap, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_mra, cmd_mrd,
    input  cmd_ready
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_ap, cmd_bg, cmd_ba, cmd_row, cmd_col, cmd_mra, cmd_mrd,
    output cmd_ready
  );
endinterface

// File: rtl/ca_pkt_engine.sv
// ca_pkt_engine: queues decoded commands and serialises them as DDR5 CA packets
// ports: clk/rst (async active-high), cmd (ca_pkt_if slave), ca/cs_n to the PHY,
// busy, fifo_level (occupancy) and err (one-cycle pulse on an illegal opcode)
module ca_pkt_engine #(
  parameter int CA_W       = 14,
  parameter int BG_W       = 3,
  parameter int BA_W       = 2,
  parameter int ROW_W      = 16,
  parameter int COL_W      = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int CMD_GAP    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  ca_pkt_if.slave                     cmd,
  output logic [CA_W-1:0]             ca,
  output logic                        cs_n,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, UI0, UI1, GAP} state_t;
  typedef struct packed {
    logic        ok;
    logic        two;
    logic [12:0] w0;
    logic [11:0] w1;
  } ent_t;
  state_t           state;
  ent_t             mem [FIFO_DEPTH];
  ent_t             enc, head;
  logic [AW-1:0]    wp, rp;
  logic [AW:0]      level;
  logic [11:0]      w1_q;
  logic             two_q, live, push, pop, done;
  logic [3:0]       cnt;
  logic [BG_W-1:0]  bg_i;
  logic [BA_W-1:0]  ba_i;
  logic [ROW_W-1:0] row_i;
  logic [COL_W-1:0] col_i;
  logic [2:0]       bg;
  logic [1:0]       ba;
  logic [15:0]      row;
  logic [9:0]       col;
  assign bg_i = cmd.cmd_bg;
  assign ba_i = cmd.cmd_ba;
  assign row_i = cmd.cmd_row;
  assign col_i = cmd.cmd_col;
  assign bg = 3'(bg_i);
  assign ba = 2'(ba_i);
  assign row = 16'(row_i);
  assign col = 10'(col_i);
  always_comb begin
    enc = '0;
    enc.ok = 1'b1;
    enc.two = 1'b1;
    case (cmd.cmd_op)
      4'd1: begin enc.w0 = {2'b0, bg, ba, row[3:0], 2'b00}; enc.w1 = row[15:4]; end
      4'd2: begin enc.w0 = {2'b0, bg, ba, 6'b011101}; enc.w1 = {1'b0, ~cmd.cmd_ap, 2'b0, col[9:2]}; end
      4'd3: begin enc.w0 = {2'b0, bg, ba, 6'b001101}; enc.w1 = {1'b0, ~cmd.cmd_ap, 2'b0, col[9:3], 1'b0}; end
      4'd4: begin enc.two = 1'b0; enc.w0 = {2'b0, bg, ba, 6'b011011}; end
      4'd5: begin enc.two = 1'b0; enc.w0 = 13'h00b; end
      4'd6: begin enc.two = 1'b0; enc.w0 = 13'h013; end
      4'd7: begin enc.w0 = {cmd.cmd_mra, 5'b00101}; enc.w1 = {4'b0, cmd.cmd_mrd}; end
      4'd8: enc.w0 = {cmd.cmd_mra, 5'b10101};
      default: enc.ok = 1'b0;
    endcase
  end
  assign head = mem[rp];
  assign done = (state == UI0 && !two_q) || state == UI1;
  assign pop = level != '0 && (state == IDLE || (done && CMD_GAP == 0) || (state == GAP && cnt == 4'd1));
  assign push = cmd.cmd_valid && cmd.cmd_ready;
  assign cmd.cmd_ready = live && level != (AW+1)'(FIFO_DEPTH);
  assign busy = state != IDLE || level != '0;
  assign fifo_level = level;
  always_ff @(posedge clk)
    if (push) mem[wp] <= enc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      ca <= '0;
      cs_n <= 1'b1;
      err <= 1'b0;
      w1_q <= '0;
      two_q <= 1'b0;
      cnt <= '0;
    end else begin
      err <= pop && !head.ok;
      if (pop && head.ok) begin
        state <= UI0;
        ca <= CA_W'(head.w0);
        cs_n <= 1'b0;
        w1_q <= head.w1;
        two_q <= head.two;
      end else if (state == UI0 && two_q) begin
        state <= UI1;
        ca <= CA_W'(w1_q);
        cs_n <= 1'b1;
      end else if (done && CMD_GAP != 0) begin
        state <= GAP;
        cnt <= 4'(CMD_GAP);
        ca <= '0;
        cs_n <= 1'b1;
      end else if (state == GAP && cnt != 4'd1) begin
        cnt <= cnt - 4'd1;
      end else begin
        state <= IDLE;
        ca <= '0;
        cs_n <= 1'b1;
      end
    end
endmodule
